// File: rtl/bpred_pkg.sv
// Shared widths, byte-enable encodings and the queued update record for the
// branch-predictor update path.
package bpred_pkg;

    localparam int PC_W       = 32;
    localparam int BIMODAL_W  = 12;
    localparam int CARRY_W    = 9;
    localparam int BTB_DATA_W = 30;

    localparam logic [3:0] BE_BIMODAL = 4'b0001;
    localparam logic [3:0] BE_ALL     = 4'b1111;

    typedef struct packed {
        logic [PC_W-1:0]      pc4;
        logic [PC_W-1:0]      target;
        logic                 dir;
        logic                 miss;
        logic [BIMODAL_W-1:0] bimodal;
        logic [CARRY_W-1:0]   carry;
    } upd_entry_t;

    function automatic logic [PC_W-1:0] correct_next_pc(
        input logic            dir,
        input logic [PC_W-1:0] target,
        input logic [PC_W-1:0] pc4
    );
        return dir ? target : pc4;
    endfunction

endpackage

// File: rtl/bpred_upd_fifo.sv
// Circular update queue: registered head, no write-to-read bypass, and a full
// flag derived only from the stored occupancy.
module bpred_upd_fifo
    import bpred_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  upd_entry_t push_entry,
    input  logic       stall,
    output upd_entry_t head_entry,
    output logic       head_valid,
    output logic       full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    upd_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full       = (count == FULL_CNT);
    assign head_valid = (count != '0);
    assign head_entry = mem[rd_ptr];
    assign do_push    = push & ~full;
    assign do_pop     = head_valid & ~stall;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !reset) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/bpred_update_unit.sv
// Branch-predictor update unit: detects mispredicts at execute, pulses a fetch
// redirect, and queues predictor updates. Optional stats: BPRED_UPD_STATS_EN.
module bpred_update_unit
    import bpred_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ex_valid,
    input  logic [PC_W-1:0]       ex_pc4,
    input  logic [PC_W-1:0]       ex_target,
    input  logic                  ex_dir,
    input  logic                  ex_pred_dir,
    input  logic [PC_W-1:0]       ex_pred_target,
    input  logic [BIMODAL_W-1:0]  ex_bimodal,
    input  logic [CARRY_W-1:0]    ex_carry,
    input  logic                  stall,
    output logic                  full,
    output logic                  upd_valid,
    output logic [PC_W-1:0]       upd_pc4,
    output logic [PC_W-1:0]       upd_target,
    output logic                  upd_dir,
    output logic                  upd_miss,
    output logic [BIMODAL_W-1:0]  upd_bimodal,
    output logic [BTB_DATA_W-1:0] upd_btb_data,
    output logic [CARRY_W-1:0]    upd_carry,
    output logic [3:0]            upd_byte_en,
    output logic                  redirect_valid,
    output logic [PC_W-1:0]       redirect_pc
`ifdef BPRED_UPD_STATS_EN
    ,
    output logic [31:0]           miss_count,
    output logic [31:0]           hit_count
`endif
);

    logic       miss;
    logic       accept;
    upd_entry_t new_entry;
    upd_entry_t head;

    assign miss   = (ex_dir != ex_pred_dir) |
                    (ex_dir & ex_pred_dir & (ex_target != ex_pred_target));
    assign accept = ex_valid & ~full;

    always_comb begin
        new_entry         = '0;
        new_entry.pc4     = ex_pc4;
        new_entry.target  = ex_target;
        new_entry.dir     = ex_dir;
        new_entry.miss    = miss;
        new_entry.bimodal = ex_bimodal;
        new_entry.carry   = ex_carry;
    end

    bpred_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (ex_valid),
        .push_entry (new_entry),
        .stall      (stall),
        .head_entry (head),
        .head_valid (upd_valid),
        .full       (full)
    );

    // Redirect stage: one-cycle pulse following an accepted mispredict.
    always_ff @(posedge clk) begin
        if (reset) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= accept & miss;
            if (accept && miss) redirect_pc <= correct_next_pc(ex_dir, ex_target, ex_pc4);
        end
    end

    assign upd_pc4      = head.pc4;
    assign upd_target   = head.target;
    assign upd_dir      = head.dir;
    assign upd_miss     = head.miss;
    assign upd_bimodal  = head.bimodal;
    assign upd_carry    = head.carry;
    assign upd_btb_data = head.target[PC_W-1:2];
    assign upd_byte_en  = head.dir ? BE_ALL : BE_BIMODAL;

`ifdef BPRED_UPD_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            miss_count <= '0;
            hit_count  <= '0;
        end else if (upd_valid && !stall) begin
            if (upd_miss) miss_count <= miss_count + 32'd1;
            else          hit_count  <= hit_count + 32'd1;
        end
    end
`endif

endmodule
